// File: rtl/button_group_arbiter.sv
// Arbitrates press pulses from N on-screen buttons into one registered click event
// per physical mouse click, with release-wait and a post-release lockout.
module button_group_arbiter #(
  parameter int N_BUTTONS      = 4,
  parameter int IDX_W          = 2,
  parameter int LOCKOUT_CYCLES = 1300000
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  input  logic [N_BUTTONS-1:0] screen_mask,
  input  logic                 mouse_left,
  input  logic [N_BUTTONS-1:0] btn_pressed,
  output logic [N_BUTTONS-1:0] btn_enable,
  output logic                 evt_valid,
  output logic [IDX_W-1:0]     evt_idx,
  input  logic                 evt_ack,
  output logic                 busy,
  output logic [1:0]           dbg_state
);

  localparam int CNT_W = (LOCKOUT_CYCLES < 1) ? 1 : $clog2(LOCKOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LOCKOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] HOLD     = 2'd1;
  localparam logic [1:0] WAIT_REL = 2'd2;
  localparam logic [1:0] LOCKOUT  = 2'd3;

  logic [1:0]           state_q, state_d;
  logic [N_BUTTONS-1:0] en_q, en_d;
  logic                 valid_q, valid_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 busy_q, busy_d;

  logic [N_BUTTONS-1:0] hit;
  logic [IDX_W-1:0]     lo_idx;

  assign hit = btn_pressed & screen_mask;

  // Scan from the top down so the lowest set bit is the last one written.
  always_comb begin
    lo_idx = '0;
    for (int i = N_BUTTONS - 1; i >= 0; i--) begin
      if (hit[i]) lo_idx = IDX_W'(i);
    end
  end

  always_comb begin
    state_d = state_q;
    en_d    = en_q;
    valid_d = valid_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        en_d = screen_mask;
        if (hit != '0) begin
          idx_d   = lo_idx;
          valid_d = 1'b1;
          en_d    = '0;
          state_d = HOLD;
        end
      end
      HOLD: begin
        en_d = '0;
        if (evt_ack) begin
          valid_d = 1'b0;
          state_d = WAIT_REL;
        end
      end
      WAIT_REL: begin
        en_d = '0;
        if (!mouse_left) begin
          if (LOCKOUT_CYCLES == 0) begin
            state_d = IDLE;
          end else begin
            cnt_d   = CNT_LOAD;
            state_d = LOCKOUT;
          end
        end
      end
      LOCKOUT: begin
        en_d = '0;
        // A fresh press restarts the wait; the counter reloads on the next release.
        if (mouse_left) begin
          state_d = WAIT_REL;
        end else if (cnt_q == CNT_ONE) begin
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      default: begin
        en_d    = '0;
        state_d = IDLE;
      end
    endcase
    if (flush) begin
      state_d = IDLE;
      valid_d = 1'b0;
      cnt_d   = '0;
      en_d    = '0;
    end
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      en_q    <= '0;
      valid_q <= 1'b0;
      idx_q   <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      en_q    <= en_d;
      valid_q <= valid_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
    end
  end

  assign btn_enable = en_q;
  assign evt_valid  = valid_q;
  assign evt_idx    = idx_q;
  assign busy       = busy_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_button_group_arbiter.sv
// Directed bench for button_group_arbiter with N_BUTTONS=4, IDX_W=2, LOCKOUT_CYCLES=8.
module tb_button_group_arbiter;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_HOLD = 2'd1;
  localparam logic [1:0] S_WREL = 2'd2;
  localparam logic [1:0] S_LOCK = 2'd3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       flush = 1'b0;
  logic [3:0] screen_mask = 4'b0000;
  logic       mouse_left = 1'b0;
  logic [3:0] btn_pressed = 4'b0000;
  logic [3:0] btn_enable;
  logic       evt_valid;
  logic [1:0] evt_idx;
  logic       evt_ack = 1'b0;
  logic       busy;
  logic [1:0] dbg_state;

  int n_checks = 0;
  int n_pass   = 0;

  button_group_arbiter #(
    .N_BUTTONS(4),
    .IDX_W(2),
    .LOCKOUT_CYCLES(8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .flush(flush),
    .screen_mask(screen_mask),
    .mouse_left(mouse_left),
    .btn_pressed(btn_pressed),
    .btn_enable(btn_enable),
    .evt_valid(evt_valid),
    .evt_idx(evt_idx),
    .evt_ack(evt_ack),
    .busy(busy),
    .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Ack the pending event, then walk through release and the 8-cycle lockout.
  task automatic ack_release_lockout(input string tag);
    evt_ack = 1'b1;
    step();
    evt_ack = 1'b0;
    check({tag, "_ack_valid"}, 32'(evt_valid), 32'd0);
    mouse_left = 1'b0;
    step();
    check({tag, "_lock_entry"}, 32'(dbg_state), 32'(S_LOCK));
    for (int i = 0; i < 7; i++) step();
    check({tag, "_lock_last"}, 32'(dbg_state), 32'(S_LOCK));
    check({tag, "_lock_en"}, 32'(btn_enable), 32'd0);
    step();
    check({tag, "_idle"}, 32'(dbg_state), 32'(S_IDLE));
    check({tag, "_idle_busy"}, 32'(busy), 32'd0);
    step();
    check({tag, "_en_back"}, 32'(btn_enable), 32'(screen_mask));
  endtask

  initial begin
    // Reset values
    #3;
    check("rst_en", 32'(btn_enable), 32'd0);
    check("rst_valid", 32'(evt_valid), 32'd0);
    check("rst_idx", 32'(evt_idx), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_state", 32'(dbg_state), 32'(S_IDLE));
    step();
    step();
    rst = 1'b0;
    screen_mask = 4'b1111;
    step();
    check("post_rst_en", 32'(btn_enable), 32'hF);

    // 1: single press idx 2, ack 3 cycles later, release, lockout
    mouse_left = 1'b1;
    btn_pressed = 4'b0100;
    step();
    btn_pressed = 4'b0000;
    check("t1_valid", 32'(evt_valid), 32'd1);
    check("t1_idx", 32'(evt_idx), 32'd2);
    check("t1_en", 32'(btn_enable), 32'd0);
    check("t1_busy", 32'(busy), 32'd1);
    step();
    step();
    check("t1_hold_idx", 32'(evt_idx), 32'd2);
    check("t1_hold_valid", 32'(evt_valid), 32'd1);
    evt_ack = 1'b1;
    step();
    evt_ack = 1'b0;
    check("t1_ack", 32'(evt_valid), 32'd0);
    check("t1_wrel", 32'(dbg_state), 32'(S_WREL));
    step();
    step();
    check("t1_wrel_hold", 32'(dbg_state), 32'(S_WREL));
    mouse_left = 1'b0;
    step();
    check("t1_lock", 32'(dbg_state), 32'(S_LOCK));
    for (int i = 0; i < 7; i++) begin
      check("t1_lock_en", 32'(btn_enable), 32'd0);
      step();
    end
    check("t1_lock_end", 32'(dbg_state), 32'(S_LOCK));
    step();
    check("t1_idle", 32'(dbg_state), 32'(S_IDLE));
    check("t1_idle_en0", 32'(btn_enable), 32'd0);
    step();
    check("t1_en", 32'(btn_enable), 32'hF);

    // 2: simultaneous hits, lowest wins, nothing queued
    btn_pressed = 4'b1010;
    step();
    btn_pressed = 4'b0000;
    check("t2_valid", 32'(evt_valid), 32'd1);
    check("t2_idx", 32'(evt_idx), 32'd1);
    ack_release_lockout("t2");
    for (int i = 0; i < 6; i++) begin
      step();
      check("t2_no_second", 32'(evt_valid), 32'd0);
    end

    // 3: masked-off button ignored
    screen_mask = 4'b0011;
    step();
    check("t3_en_mask", 32'(btn_enable), 32'h3);
    btn_pressed = 4'b0100;
    step();
    check("t3_masked_valid", 32'(evt_valid), 32'd0);
    check("t3_masked_en", 32'(btn_enable), 32'h3);
    check("t3_masked_state", 32'(dbg_state), 32'(S_IDLE));
    btn_pressed = 4'b0001;
    step();
    btn_pressed = 4'b0000;
    check("t3_valid", 32'(evt_valid), 32'd1);
    check("t3_idx", 32'(evt_idx), 32'd0);
    ack_release_lockout("t3");

    // 4: long hold then re-press in lockout cycle 4
    screen_mask = 4'b1111;
    step();
    mouse_left = 1'b1;
    btn_pressed = 4'b1000;
    step();
    btn_pressed = 4'b0000;
    check("t4_idx", 32'(evt_idx), 32'd3);
    evt_ack = 1'b1;
    step();
    evt_ack = 1'b0;
    for (int i = 0; i < 50; i++) step();
    check("t4_wrel_long", 32'(dbg_state), 32'(S_WREL));
    mouse_left = 1'b0;
    step();
    check("t4_lock", 32'(dbg_state), 32'(S_LOCK));
    step();
    step();
    step();
    mouse_left = 1'b1;
    step();
    check("t4_repress", 32'(dbg_state), 32'(S_WREL));
    step();
    step();
    check("t4_wrel_again", 32'(dbg_state), 32'(S_WREL));
    mouse_left = 1'b0;
    step();
    for (int i = 0; i < 7; i++) begin
      check("t4_lock2", 32'(dbg_state), 32'(S_LOCK));
      step();
    end
    check("t4_lock2_end", 32'(dbg_state), 32'(S_LOCK));
    step();
    check("t4_idle", 32'(dbg_state), 32'(S_IDLE));
    for (int i = 0; i < 5; i++) step();
    check("t4_no_event", 32'(evt_valid), 32'd0);
    check("t4_en", 32'(btn_enable), 32'hF);

    // 5: flush with ack in HOLD drops the event
    btn_pressed = 4'b0010;
    step();
    btn_pressed = 4'b0000;
    check("t5_valid", 32'(evt_valid), 32'd1);
    flush = 1'b1;
    evt_ack = 1'b1;
    step();
    flush = 1'b0;
    evt_ack = 1'b0;
    check("t5_flush_valid", 32'(evt_valid), 32'd0);
    check("t5_flush_state", 32'(dbg_state), 32'(S_IDLE));
    check("t5_flush_en", 32'(btn_enable), 32'd0);
    check("t5_flush_busy", 32'(busy), 32'd0);
    step();
    check("t5_en", 32'(btn_enable), 32'hF);
    check("t5_no_event", 32'(evt_valid), 32'd0);

    // 6: async reset in the middle of lockout
    mouse_left = 1'b1;
    btn_pressed = 4'b0001;
    step();
    btn_pressed = 4'b0000;
    evt_ack = 1'b1;
    step();
    evt_ack = 1'b0;
    mouse_left = 1'b0;
    step();
    step();
    step();
    check("t6_lock", 32'(dbg_state), 32'(S_LOCK));
    check("t6_busy", 32'(busy), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    check("t6_async_state", 32'(dbg_state), 32'(S_IDLE));
    check("t6_async_busy", 32'(busy), 32'd0);
    check("t6_async_en", 32'(btn_enable), 32'd0);
    check("t6_async_valid", 32'(evt_valid), 32'd0);
    check("t6_async_idx", 32'(evt_idx), 32'd0);
    step();
    rst = 1'b0;
    step();
    check("t6_post_en", 32'(btn_enable), 32'hF);
    check("t6_post_valid", 32'(evt_valid), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
